// File: rtl/wb_stage_param.sv
// MEM/WB pipeline register with write-back result select for the 5-stage RISC-V core.
// Load data is extracted and extended here from the raw aligned memory word captured from M.
module wb_stage_param #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallW,
    input  logic              flushW,
    input  logic              validM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        funct3M,
    input  logic [REG_AW-1:0] rdM,
    input  logic [XLEN-1:0]   PCplus4M,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   ReadDataM,
    output logic              validW,
    output logic              RegWriteW,
    output logic [REG_AW-1:0] rdW,
    output logic [1:0]        ResultSrcW,
    output logic [XLEN-1:0]   ResultW,
    output logic [CNT_W-1:0]  instretW
);

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [1:0]        src_q,      src_d;
    logic [2:0]        f3_q,       f3_d;
    logic [XLEN-1:0]   alu_q,      alu_d;
    logic [XLEN-1:0]   pc4_q,      pc4_d;
    logic [XLEN-1:0]   rdata_q,    rdata_d;
    logic [CNT_W-1:0]  instret_q,  instret_d;

    function automatic logic [7:0] lane8(input logic [XLEN-1:0] d, input logic [2:0] o);
        return 8'(d >> {o, 3'b000});
    endfunction

    function automatic logic [15:0] lane16(input logic [XLEN-1:0] d, input logic [2:0] o);
        return 16'(d >> {o, 3'b000});
    endfunction

    function automatic logic [31:0] lane32(input logic [XLEN-1:0] d, input logic [2:0] o);
        return 32'(d >> {o, 3'b000});
    endfunction

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
        return XLEN'(b);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
        return XLEN'(h);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] w);
        return XLEN'(w);
    endfunction

    // Priority below reset (handled in the register process): flush > stall > capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        src_d      = src_q;
        f3_d       = f3_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        rdata_d    = rdata_q;
        instret_d  = instret_q;
        if (flushW) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            rd_d       = '0;
            src_d      = '0;
            f3_d       = '0;
            alu_d      = '0;
            pc4_d      = '0;
            rdata_d    = '0;
        end else if (!stallW) begin
            valid_d    = validM;
            regwrite_d = RegWriteM & validM & (rdM != '0);
            rd_d       = rdM;
            src_d      = ResultSrcM;
            f3_d       = funct3M;
            alu_d      = ALUResultM;
            pc4_d      = PCplus4M;
            rdata_d    = ReadDataM;
            instret_d  = instret_q + CNT_W'(validM);
        end
    end

    // ---- M -> W register boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            src_q      <= '0;
            f3_q       <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            rdata_q    <= '0;
            instret_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            src_q      <= src_d;
            f3_q       <= f3_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            rdata_q    <= rdata_d;
            instret_q  <= instret_d;
        end
    end

    // Offset bit 2 only exists for XLEN=64; ignored low bits give the halfword/word lane.
    logic [2:0]      off, off_h, off_w;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic [XLEN-1:0] load_data;

    assign off   = (XLEN == 64) ? alu_q[2:0] : {1'b0, alu_q[1:0]};
    assign off_h = {off[2:1], 1'b0};
    assign off_w = {off[2], 2'b00};
    assign ld_b  = lane8(rdata_q, off);
    assign ld_h  = lane16(rdata_q, off_h);
    assign ld_w  = lane32(rdata_q, off_w);

    always_comb begin
        load_data = rdata_q;
        case (f3_q)
            3'b000:  load_data = sext8(ld_b);
            3'b001:  load_data = sext16(ld_h);
            3'b010:  load_data = sext32(ld_w);
            3'b011:  load_data = (XLEN == 64) ? rdata_q : sext32(ld_w);
            3'b100:  load_data = XLEN'(ld_b);
            3'b101:  load_data = XLEN'(ld_h);
            3'b110:  load_data = (XLEN == 64) ? XLEN'(ld_w) : sext32(ld_w);
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        ResultW = '0;
        case (src_q)
            2'b00:   ResultW = alu_q;
            2'b01:   ResultW = load_data;
            2'b10:   ResultW = pc4_q;
            default: ResultW = '0;
        endcase
    end

    assign validW     = valid_q;
    assign RegWriteW  = regwrite_q;
    assign rdW        = rd_q;
    assign ResultSrcW = src_q;
    assign instretW   = instret_q;

endmodule

// File: tb/tb_wb_stage_param.sv
// Scoreboard bench for wb_stage_param: a default 32-bit instance, a 4-bit counter instance
// and a 64-bit instance share control inputs; every cycle's expected W state is queued and checked.
module tb_wb_stage_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stallW, flushW, validM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] pc32, alu32, rdat32;
    logic [63:0] pc64, alu64, rdat64;

    logic        a_validW, a_RegWriteW, b_validW, b_RegWriteW, c_validW, c_RegWriteW;
    logic [4:0]  a_rdW, b_rdW, c_rdW;
    logic [1:0]  a_srcW, b_srcW, c_srcW;
    logic [31:0] a_ResultW, b_ResultW;
    logic [63:0] c_ResultW, a_instretW, c_instretW;
    logic [3:0]  b_instretW;

    wb_stage_param u_a (
        .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW), .validM(validM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .rdM(rdM),
        .PCplus4M(pc32), .ALUResultM(alu32), .ReadDataM(rdat32),
        .validW(a_validW), .RegWriteW(a_RegWriteW), .rdW(a_rdW), .ResultSrcW(a_srcW),
        .ResultW(a_ResultW), .instretW(a_instretW)
    );

    wb_stage_param #(.CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW), .validM(validM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .rdM(rdM),
        .PCplus4M(pc32), .ALUResultM(alu32), .ReadDataM(rdat32),
        .validW(b_validW), .RegWriteW(b_RegWriteW), .rdW(b_rdW), .ResultSrcW(b_srcW),
        .ResultW(b_ResultW), .instretW(b_instretW)
    );

    wb_stage_param #(.XLEN(64)) u_c (
        .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW), .validM(validM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .rdM(rdM),
        .PCplus4M(pc64), .ALUResultM(alu64), .ReadDataM(rdat64),
        .validW(c_validW), .RegWriteW(c_RegWriteW), .rdW(c_rdW), .ResultSrcW(c_srcW),
        .ResultW(c_ResultW), .instretW(c_instretW)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] r32;
        logic [63:0] r64;
        logic [63:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] load_model(input bit is64, input logic [2:0] f3,
                                               input logic [63:0] addr, input logic [63:0] data);
        logic [7:0]  b[8];
        logic [15:0] h;
        logic [31:0] w;
        int o, oh, ow;
        for (int i = 0; i < 8; i++) b[i] = data[8*i +: 8];
        o  = is64 ? int'(addr[2:0]) : int'(addr[1:0]);
        oh = o - (o % 2);
        ow = is64 ? (o / 4) * 4 : 0;
        h  = {b[oh+1], b[oh]};
        w  = {b[ow+3], b[ow+2], b[ow+1], b[ow]};
        case (f3)
            3'd0:    return {{56{b[o][7]}}, b[o]};
            3'd1:    return {{48{h[15]}}, h};
            3'd2:    return {{32{w[31]}}, w};
            3'd3:    return is64 ? data : {{32{w[31]}}, w};
            3'd4:    return {56'd0, b[o]};
            3'd5:    return {48'd0, h};
            3'd6:    return is64 ? {32'd0, w} : {{32{w[31]}}, w};
            default: return data;
        endcase
    endfunction

    function automatic logic [63:0] sel_model(input bit is64, input logic [1:0] src, input logic [2:0] f3,
                                              input logic [63:0] alu, input logic [63:0] pc,
                                              input logic [63:0] data);
        case (src)
            2'd0:    return alu;
            2'd1:    return load_model(is64, f3, alu, data);
            2'd2:    return pc;
            default: return 64'd0;
        endcase
    endfunction

    // One clock: predict W state from the current inputs, queue it, then compare after the edge.
    task automatic tick();
        exp_t n, e;
        logic [63:0] t;
        n = m;
        if (reset) begin
            n = '{default: '0};
        end else if (flushW) begin
            n = '{default: '0};
            n.cnt = m.cnt;
        end else if (!stallW) begin
            n.v   = validM;
            n.rw  = RegWriteM && validM && (rdM != 5'd0);
            n.rd  = rdM;
            n.src = ResultSrcM;
            t     = sel_model(1'b0, ResultSrcM, funct3M, {32'd0, alu32}, {32'd0, pc32}, {32'd0, rdat32});
            n.r32 = t[31:0];
            n.r64 = sel_model(1'b1, ResultSrcM, funct3M, alu64, pc64, rdat64);
            n.cnt = m.cnt + 64'(validM);
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("a_validW",    64'(a_validW),    64'(e.v));
        check("a_RegWriteW", 64'(a_RegWriteW), 64'(e.rw));
        check("a_rdW",       64'(a_rdW),       64'(e.rd));
        check("a_srcW",      64'(a_srcW),      64'(e.src));
        check("a_ResultW",   64'(a_ResultW),   64'(e.r32));
        check("a_instretW",  a_instretW,       e.cnt);
        check("b_ResultW",   64'(b_ResultW),   64'(e.r32));
        check("b_instretW",  64'(b_instretW),  64'(e.cnt[3:0]));
        check("c_RegWriteW", 64'(c_RegWriteW), 64'(e.rw));
        check("c_ResultW",   c_ResultW,        e.r64);
        check("c_instretW",  c_instretW,       e.cnt);
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] rdat);
        validM = v;  RegWriteM = rw; ResultSrcM = src; funct3M = f3; rdM = rd;
        alu32 = alu; pc32 = pc; rdat32 = rdat;
        alu64 = {32'd0, alu}; pc64 = {32'd0, pc}; rdat64 = {32'd0, rdat};
    endtask

    logic [2:0]  tf3[6]  = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  toff[6] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] tres[6] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01};
    logic [2:0]  sweep[5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};

    initial begin
        m = '{default: '0};
        reset = 1'b1; stallW = 1'b0; flushW = 1'b0;
        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd3, 32'hDEAD, 32'h4, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd5, 32'h1234, 32'h8, 32'h0);
        tick();
        check("alu_result", 64'(a_ResultW), 64'h1234);

        foreach (sweep[i])
            for (int off = 0; off < 4; off++) begin
                set_m(1'b1, 1'b1, 2'd1, sweep[i], 5'd3, 32'h1000 + 32'(off), 32'h0, 32'h80FF7F01);
                tick();
            end
        for (int i = 0; i < 6; i++) begin
            set_m(1'b1, 1'b1, 2'd1, tf3[i], 5'd4, 32'h2000 | 32'(toff[i]), 32'h0, 32'h80FF7F01);
            tick();
            check("load_table", 64'(a_ResultW), 64'(tres[i]));
        end
        set_m(1'b1, 1'b1, 2'd1, 3'd7, 5'd4, 32'h2003, 32'h0, 32'h80FF7F01);
        tick();

        set_m(1'b1, 1'b1, 2'd2, 3'd0, 5'd1, 32'h55, 32'h104, 32'h0);
        tick();
        check("jal_result", 64'(a_ResultW), 64'h104);
        set_m(1'b1, 1'b1, 2'd2, 3'd0, 5'd0, 32'h55, 32'h104, 32'h0);
        tick();
        check("x0_suppress", 64'(a_RegWriteW), 64'd0);
        set_m(1'b1, 1'b1, 2'd3, 3'd0, 5'd2, 32'h55, 32'h104, 32'h0);
        tick();

        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'hAAAA, 32'h10, 32'h0);
        tick();
        stallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_m(1'b1, 1'b1, 2'(i), 3'(i), 5'(i + 10), 32'h5000 + 32'(i), 32'h600, 32'h12345678);
            tick();
            check("stall_hold", 64'(a_ResultW), 64'hAAAA);
        end
        flushW = 1'b1;
        tick();
        check("flush_valid", 64'(a_validW), 64'd0);
        stallW = 1'b0; flushW = 1'b0;

        set_m(1'b0, 1'b1, 2'd0, 3'd0, 5'd9, 32'h77, 32'h0, 32'h0);
        tick();
        check("bubble_rw", 64'(a_RegWriteW), 64'd0);

        set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd8, 32'h88, 32'h0, 32'h0);
        tick();
        stallW = 1'b1; reset = 1'b1;
        tick();
        flushW = 1'b1;
        tick();
        stallW = 1'b0; flushW = 1'b0; reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            set_m(1'b1, 1'b1, 2'd0, 3'd0, 5'd6, 32'(i), 32'h0, 32'h0);
            tick();
        end
        check("cnt4_wrap", 64'(b_instretW), 64'd1);
        check("cnt64_17", a_instretW, 64'd17);

        set_m(1'b1, 1'b1, 2'd1, 3'd2, 5'd3, 32'h0, 32'h0, 32'h80000000);
        rdat64 = 64'h00000000_80000000;
        tick();
        check("lw64", c_ResultW, 64'hFFFFFFFF_80000000);
        set_m(1'b1, 1'b1, 2'd1, 3'd6, 5'd3, 32'h0, 32'h0, 32'h80000000);
        rdat64 = 64'h00000000_80000000;
        tick();
        check("lwu64", c_ResultW, 64'h00000000_80000000);
        set_m(1'b1, 1'b1, 2'd1, 3'd3, 5'd3, 32'h0, 32'h0, 32'h44332211);
        rdat64 = 64'h88776655_44332211;
        tick();
        check("ld64", c_ResultW, 64'h88776655_44332211);
        set_m(1'b1, 1'b1, 2'd1, 3'd0, 5'd3, 32'h7, 32'h0, 32'h44332211);
        alu64 = 64'h7; rdat64 = 64'h88776655_44332211;
        tick();
        check("lb64_off7", c_ResultW, 64'hFFFFFFFF_FFFFFF88);
        set_m(1'b1, 1'b1, 2'd1, 3'd2, 5'd3, 32'h4, 32'h0, 32'h44332211);
        alu64 = 64'h6; rdat64 = 64'h88776655_44332211;
        tick();
        check("lw64_hi", c_ResultW, 64'hFFFFFFFF_88776655);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
